// File: rtl/mul_datapath_if.sv
// Controller <-> datapath bundle for the shift-free multiplier datapath.
// The controller drives operands and control strobes; the datapath returns status and the product.
interface mul_datapath_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0]   data_in;
  logic               ldA;
  logic               ldB;
  logic               ldP;
  logic               clrP;
  logic               decQ;
  logic               eqz;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output data_in, ldA, ldB, ldP, clrP, decQ,
    input  eqz, product, busy
  );

  modport slave (
    input  data_in, ldA, ldB, ldP, clrP, decQ,
    output eqz, product, busy
  );
endinterface

// File: rtl/mul_datapath.sv
// Repeated-addition multiplier datapath: A is added into P once per count of B.
// B counts down and saturates at zero, which also gates accumulation so P ends at exactly A*B.
module mul_datapath #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  mul_datapath_if.slave bus
);
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   b_next;
  logic [2*WIDTH-1:0] p_reg;
  logic [2*WIDTH-1:0] p_next;
  logic               busy_reg;
  logic               busy_next;
  logic               b_zero;

  assign b_zero = (b_reg == '0);

  always_comb begin
    b_next = b_reg;
    if (bus.ldB) begin
      b_next = bus.data_in;
    end else if (bus.decQ && !b_zero) begin
      b_next = b_reg - WIDTH'(1);
    end

    // Accumulation is suppressed at B == 0 so the controller's exit-edge strobe is harmless.
    p_next = p_reg;
    if (bus.clrP) begin
      p_next = '0;
    end else if (bus.ldP && !b_zero) begin
      p_next = p_reg + {{WIDTH{1'b0}}, a_reg};
    end

    busy_next = busy_reg;
    if (bus.ldB || (b_next == '0)) begin
      busy_next = 1'b0;
    end else if (bus.ldP || bus.decQ) begin
      busy_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      p_reg    <= '0;
      busy_reg <= 1'b0;
    end else begin
      if (bus.ldA) begin
        a_reg <= bus.data_in;
      end
      b_reg    <= b_next;
      p_reg    <= p_next;
      busy_reg <= busy_next;
    end
  end

  assign bus.eqz     = b_zero;
  assign bus.product = p_reg;
  assign bus.busy    = busy_reg;
endmodule
